// File: rtl/eb1_dma_addrcheck_rsp_if.sv
// DMA request/response and memory-side bus bundle for the DMA address checker.
interface eb1_dma_addrcheck_rsp_if;
  logic        dma_req_valid;
  logic        dma_req_ready;
  logic        dma_req_write;
  logic [31:0] dma_req_addr;
  logic [2:0]  dma_req_sz;
  logic [63:0] dma_req_wdata;
  logic [2:0]  dma_req_tag;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_dccm;
  logic        mem_req_iccm;
  logic        mem_req_pic;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [2:0]  mem_req_sz;
  logic [63:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        mem_rsp_ecc_err;

  logic        dma_rsp_valid;
  logic        dma_rsp_ready;
  logic [2:0]  dma_rsp_tag;
  logic [63:0] dma_rsp_data;
  logic [1:0]  dma_rsp_err;
  logic [7:0]  dma_err_cnt;

  // Checker side: accepts DMA requests, issues memory requests, returns responses.
  modport slave (
    input  dma_req_valid, dma_req_write, dma_req_addr, dma_req_sz, dma_req_wdata, dma_req_tag,
    output dma_req_ready,
    output mem_req_valid, mem_req_dccm, mem_req_iccm, mem_req_pic, mem_req_write,
    output mem_req_addr, mem_req_sz, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_ecc_err,
    output dma_rsp_valid, dma_rsp_tag, dma_rsp_data, dma_rsp_err, dma_err_cnt,
    input  dma_rsp_ready
  );

  // Environment side: DMA master plus memory.
  modport master (
    output dma_req_valid, dma_req_write, dma_req_addr, dma_req_sz, dma_req_wdata, dma_req_tag,
    input  dma_req_ready,
    input  mem_req_valid, mem_req_dccm, mem_req_iccm, mem_req_pic, mem_req_write,
    input  mem_req_addr, mem_req_sz, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_ecc_err,
    input  dma_rsp_valid, dma_rsp_tag, dma_rsp_data, dma_rsp_err, dma_err_cnt,
    output dma_rsp_ready
  );
endinterface

// File: rtl/eb1_dma_addrcheck_rsp.sv
// DMA address checker: decodes DCCM/ICCM/PIC, flags DECERR/SLVERR, runs one
// transaction at a time to memory and returns a tagged response.
module eb1_dma_addrcheck_rsp #(
  parameter logic [31:0] DCCM_SADR     = 32'hF004_0000,
  parameter int unsigned DCCM_SIZE     = 64,
  parameter logic [31:0] ICCM_SADR     = 32'hEE00_0000,
  parameter int unsigned ICCM_SIZE     = 64,
  parameter logic [31:0] PIC_BASE_ADDR = 32'hF00C_0000,
  parameter int unsigned PIC_SIZE      = 32
) (
  input  logic                          clk,
  input  logic                          rst_l,
  eb1_dma_addrcheck_rsp_if.slave        bus
);
  localparam int unsigned AW = 33;
  localparam logic [AW-1:0] DCCM_LO = AW'(DCCM_SADR);
  localparam logic [AW-1:0] DCCM_HI = AW'(DCCM_SADR) + AW'(DCCM_SIZE) * AW'(1024);
  localparam logic [AW-1:0] ICCM_LO = AW'(ICCM_SADR);
  localparam logic [AW-1:0] ICCM_HI = AW'(ICCM_SADR) + AW'(ICCM_SIZE) * AW'(1024);
  localparam logic [AW-1:0] PIC_LO  = AW'(PIC_BASE_ADDR);
  localparam logic [AW-1:0] PIC_HI  = AW'(PIC_BASE_ADDR) + AW'(PIC_SIZE) * AW'(1024);

  localparam logic [1:0] ERR_OKAY = 2'b00;
  localparam logic [1:0] ERR_SLV  = 2'b10;
  localparam logic [1:0] ERR_DEC  = 2'b11;

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RSP} state_e;

  state_e      state_q, state_d;
  logic        ready_q, mem_req_valid_q, rsp_valid_q;
  logic        accept;
  logic [31:0] addr_q;
  logic [2:0]  sz_q, tag_q, region_q;
  logic        write_q;
  logic [63:0] wdata_q, rsp_data_q;
  logic [1:0]  rsp_err_q;
  logic [7:0]  err_cnt_q;

  logic [AW-1:0] start_a, end_a;
  logic [2:0]    s_hit, e_hit;
  logic [31:0]   align_mask;
  logic          decerr, slverr;
  logic [1:0]    chk_err;

  function automatic logic in_rgn(input logic [AW-1:0] a, input logic [AW-1:0] lo,
                                  input logic [AW-1:0] hi);
    return (a >= lo) && (a < hi);
  endfunction

  // Address/size check on the incoming request; region vector is {pic, iccm, dccm}.
  always_comb begin
    start_a    = {1'b0, bus.dma_req_addr};
    end_a      = start_a + (AW'(1) << bus.dma_req_sz) - AW'(1);
    s_hit      = {in_rgn(start_a, PIC_LO, PIC_HI), in_rgn(start_a, ICCM_LO, ICCM_HI),
                  in_rgn(start_a, DCCM_LO, DCCM_HI)};
    e_hit      = {in_rgn(end_a, PIC_LO, PIC_HI), in_rgn(end_a, ICCM_LO, ICCM_HI),
                  in_rgn(end_a, DCCM_LO, DCCM_HI)};
    align_mask = (32'(1) << bus.dma_req_sz) - 32'(1);
    decerr     = end_a[AW-1] | (s_hit == 3'b000) | (s_hit != e_hit);
    slverr     = (bus.dma_req_sz > 3'd3) | ((bus.dma_req_addr & align_mask) != 32'h0) |
                 (s_hit[2] & (bus.dma_req_sz != 3'd2));
    chk_err    = decerr ? ERR_DEC : (slverr ? ERR_SLV : ERR_OKAY);
  end

  // Next-state logic; mem_rsp_valid only matters while waiting for read data.
  always_comb begin
    state_d = state_q;
    accept  = ready_q & bus.dma_req_valid;
    case (state_q)
      IDLE:     if (accept) state_d = (chk_err != ERR_OKAY) ? RSP : MEM_REQ;
      MEM_REQ:  if (bus.mem_req_ready) state_d = write_q ? RSP : MEM_WAIT;
      MEM_WAIT: if (bus.mem_rsp_valid) state_d = RSP;
      RSP:      if (bus.dma_rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register with registered handshake outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q         <= IDLE;
      ready_q         <= 1'b0;
      mem_req_valid_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      ready_q         <= (state_d == IDLE);
      mem_req_valid_q <= (state_d == MEM_REQ);
      rsp_valid_q     <= (state_d == RSP);
    end
  end

  // Request capture, response capture and saturating error counter.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      addr_q     <= '0;
      sz_q       <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      tag_q      <= '0;
      region_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OKAY;
      err_cnt_q  <= '0;
    end else begin
      if ((state_q == IDLE) && accept) begin
        addr_q     <= bus.dma_req_addr;
        sz_q       <= bus.dma_req_sz;
        write_q    <= bus.dma_req_write;
        wdata_q    <= bus.dma_req_wdata;
        tag_q      <= bus.dma_req_tag;
        region_q   <= (chk_err == ERR_OKAY) ? s_hit : 3'b000;
        rsp_err_q  <= chk_err;
        rsp_data_q <= '0;
      end
      if ((state_q == MEM_WAIT) && bus.mem_rsp_valid) begin
        rsp_data_q <= bus.mem_rsp_data;
        rsp_err_q  <= bus.mem_rsp_ecc_err ? ERR_SLV : ERR_OKAY;
      end
      if (rsp_valid_q && bus.dma_rsp_ready && (rsp_err_q != ERR_OKAY) && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.dma_req_ready = ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_dccm  = region_q[0];
  assign bus.mem_req_iccm  = region_q[1];
  assign bus.mem_req_pic   = region_q[2];
  assign bus.mem_req_write = write_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_sz    = sz_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.dma_rsp_valid = rsp_valid_q;
  assign bus.dma_rsp_tag   = tag_q;
  assign bus.dma_rsp_data  = rsp_data_q;
  assign bus.dma_rsp_err   = rsp_err_q;
  assign bus.dma_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_eb1_dma_addrcheck_rsp.sv
// Scoreboard bench for eb1_dma_addrcheck_rsp: stimulus pushes expected memory
// requests and responses; memory model and response monitor pop and compare.
module tb_eb1_dma_addrcheck_rsp;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  eb1_dma_addrcheck_rsp_if bus();

  eb1_dma_addrcheck_rsp dut (.clk(clk), .rst_l(rst_l), .bus(bus));

  typedef struct packed {
    logic [2:0]  tag;
    logic [63:0] data;
    logic [1:0]  err;
  } rsp_t;

  typedef struct packed {
    logic [2:0]  rgn;
    logic        write;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [63:0] wdata;
  } mreq_t;

  rsp_t  rsp_q[$];
  mreq_t mem_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  int          mem_gnt_dly = 0;
  int          mem_rsp_dly = 1;
  logic [63:0] mem_data    = '0;
  logic        mem_ecc     = 1'b0;
  logic        mem_junk    = 1'b0;
  int          rsp_stall   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: checks each request, grants after mem_gnt_dly, returns read data.
  initial begin : mem_model
    mreq_t m, snap;
    logic  wr;
    bus.mem_req_ready   = 1'b0;
    bus.mem_rsp_valid   = 1'b0;
    bus.mem_rsp_data    = '0;
    bus.mem_rsp_ecc_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_l && bus.mem_req_valid) begin
        snap = '{rgn: {bus.mem_req_pic, bus.mem_req_iccm, bus.mem_req_dccm},
                 write: bus.mem_req_write, sz: bus.mem_req_sz,
                 addr: bus.mem_req_addr, wdata: bus.mem_req_wdata};
        chk("mem_req_expected", 128'(mem_q.size() != 0), 128'(1));
        if (mem_q.size() != 0) begin
          m = mem_q.pop_front();
          chk("mem_req_payload", 128'(snap), 128'(m));
        end
        for (int i = 0; i < mem_gnt_dly; i++) begin
          @(negedge clk);
          chk("mem_req_stable", {bus.mem_req_valid, bus.mem_req_pic, bus.mem_req_iccm,
              bus.mem_req_dccm, bus.mem_req_write, bus.mem_req_sz, bus.mem_req_addr,
              bus.mem_req_wdata}, {1'b1, snap});
        end
        wr = bus.mem_req_write;
        bus.mem_req_ready = 1'b1;
        if (mem_junk) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = ~mem_data;
        end
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        if (!wr) begin
          for (int i = 1; i < mem_rsp_dly; i++) begin
            @(posedge clk); #1;
          end
          bus.mem_rsp_valid   = 1'b1;
          bus.mem_rsp_data    = mem_data;
          bus.mem_rsp_ecc_err = mem_ecc;
          @(posedge clk); #1;
          bus.mem_rsp_valid   = 1'b0;
          bus.mem_rsp_ecc_err = 1'b0;
        end
      end
    end
  end

  // Response monitor: holds off ready for rsp_stall cycles, checks stability, pops and compares.
  initial begin : rsp_monitor
    rsp_t got, e;
    bus.dma_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_l && bus.dma_rsp_valid) begin
        got = '{tag: bus.dma_rsp_tag, data: bus.dma_rsp_data, err: bus.dma_rsp_err};
        for (int i = 0; i < rsp_stall; i++) begin
          @(negedge clk);
          chk("rsp_stable", {bus.dma_rsp_valid, bus.dma_rsp_tag, bus.dma_rsp_data, bus.dma_rsp_err},
              {1'b1, got});
        end
        bus.dma_rsp_ready = 1'b1;
        chk("rsp_expected", 128'(rsp_q.size() != 0), 128'(1));
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          chk("rsp_tag", 128'(got.tag), 128'(e.tag));
          chk("rsp_data", 128'(got.data), 128'(e.data));
          chk("rsp_err", 128'(got.err), 128'(e.err));
        end
        @(posedge clk); #1;
        bus.dma_rsp_ready = 1'b0;
      end
    end
  end

  // One complete transaction; rgn is the expected one-hot region (0 for a faulting request).
  task automatic send(input logic [31:0] addr, input logic [2:0] sz, input logic wr,
                      input logic [63:0] wd, input logic [2:0] tag, input logic [2:0] rgn,
                      input logic [63:0] edata, input logic [1:0] eerr);
    int n;
    rsp_q.push_back('{tag: tag, data: edata, err: eerr});
    if (rgn != 3'b000)
      mem_q.push_back('{rgn: rgn, write: wr, sz: sz, addr: addr, wdata: wd});
    @(negedge clk);
    bus.dma_req_valid = 1'b1;
    bus.dma_req_addr  = addr;
    bus.dma_req_sz    = sz;
    bus.dma_req_write = wr;
    bus.dma_req_wdata = wd;
    bus.dma_req_tag   = tag;
    n = 0;
    while (!bus.dma_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 128'(bus.dma_req_ready), 128'(1));
    @(posedge clk); #1;
    bus.dma_req_valid = 1'b0;
    @(negedge clk);
    if (rgn == 3'b000) begin
      chk("fault_rsp_next_cycle", 128'(bus.dma_rsp_valid), 128'(1));
      chk("fault_no_mem_req", 128'(bus.mem_req_valid), 128'(0));
    end else begin
      chk("mem_req_next_cycle", 128'(bus.mem_req_valid), 128'(1));
    end
    n = 0;
    while (!(bus.dma_req_ready && rsp_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("txn_done_in_time", 128'(bus.dma_req_ready && rsp_q.size() == 0), 128'(1));
    if (eerr != 2'b00 && exp_cnt < 255) exp_cnt++;
    chk("err_cnt", 128'(bus.dma_err_cnt), 128'(exp_cnt));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.dma_req_valid = 1'b0;
    bus.dma_req_addr  = '0;
    bus.dma_req_sz    = '0;
    bus.dma_req_write = 1'b0;
    bus.dma_req_wdata = '0;
    bus.dma_req_tag   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(bus.dma_req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(bus.dma_rsp_valid), 128'(0));
    chk("rst_mem_valid", 128'(bus.mem_req_valid), 128'(0));
    chk("rst_err_cnt", 128'(bus.dma_err_cnt), 128'(0));
    rst_l = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 128'(bus.dma_req_ready), 128'(1));

    // DCCM read, data two cycles after mem handshake
    mem_rsp_dly = 2; mem_data = 64'h1122_3344_5566_7788;
    send(32'hF004_0010, 3'd3, 1'b0, '0, 3'd5, 3'b001, 64'h1122_3344_5566_7788, 2'b00);

    // Unmapped write -> DECERR, count 1
    send(32'h4000_0000, 3'd2, 1'b1, 64'hAAAA, 3'd1, 3'b000, '0, 2'b11);
    chk("err_cnt_first", 128'(bus.dma_err_cnt), 128'(1));

    // PIC misaligned, PIC wrong size
    send(32'hF00C_0002, 3'd2, 1'b0, '0, 3'd2, 3'b000, '0, 2'b10);
    send(32'hF00C_0000, 3'd1, 1'b0, '0, 3'd3, 3'b000, '0, 2'b10);

    // End crosses DCCM top; end wraps past 2^32
    send(32'hF004_FFFC, 3'd3, 1'b0, '0, 3'd4, 3'b000, '0, 2'b11);
    send(32'hFFFF_FFFC, 3'd3, 1'b0, '0, 3'd6, 3'b000, '0, 2'b11);

    // sz > 3 inside DCCM -> SLVERR; ICCM top+1 -> DECERR
    send(32'hF004_0000, 3'd4, 1'b0, '0, 3'd7, 3'b000, '0, 2'b10);
    send(32'hEE01_0000, 3'd0, 1'b0, '0, 3'd0, 3'b000, '0, 2'b11);

    // Legal PIC read with delayed grant
    mem_gnt_dly = 2; mem_rsp_dly = 1; mem_data = 64'h0000_0000_A5A5_5A5A;
    send(32'hF00C_0004, 3'd2, 1'b0, '0, 3'd4, 3'b100, 64'h0000_0000_A5A5_5A5A, 2'b00);

    // Legal ICCM write: OKAY, data 0
    mem_gnt_dly = 1;
    send(32'hEE00_0008, 3'd3, 1'b1, 64'hCAFE_F00D_1234_5678, 3'd6, 3'b010, '0, 2'b00);

    // Last doubleword of DCCM; a same-cycle mem_rsp_valid must be ignored
    mem_gnt_dly = 0; mem_junk = 1'b1; mem_rsp_dly = 3; mem_data = 64'h0123_4567_89AB_CDEF;
    send(32'hF004_FFF8, 3'd3, 1'b0, '0, 3'd2, 3'b001, 64'h0123_4567_89AB_CDEF, 2'b00);
    mem_junk = 1'b0;

    // ICCM read with ECC error and stalled response ready
    rsp_stall = 3; mem_rsp_dly = 1; mem_ecc = 1'b1; mem_data = 64'hDEAD_BEEF_0BAD_F00D;
    send(32'hEE00_0040, 3'd3, 1'b0, '0, 3'd3, 3'b010, 64'hDEAD_BEEF_0BAD_F00D, 2'b10);
    rsp_stall = 0; mem_ecc = 1'b0;

    // Counter saturation
    for (int i = 0; i < 300; i++)
      send(32'h4000_0000 + 32'(i * 8), 3'd3, 1'b0, '0, 3'(i), 3'b000, '0, 2'b11);
    chk("err_cnt_saturated", 128'(bus.dma_err_cnt), 128'(8'hFF));

    // Reset during MEM_WAIT: transaction abandoned, late mem response ignored
    mem_rsp_dly = 6; mem_data = 64'h5555_6666_7777_8888;
    mem_q.push_back('{rgn: 3'b010, write: 1'b0, sz: 3'd3, addr: 32'hEE00_0100, wdata: '0});
    @(negedge clk);
    bus.dma_req_valid = 1'b1; bus.dma_req_addr = 32'hEE00_0100; bus.dma_req_sz = 3'd3;
    bus.dma_req_write = 1'b0; bus.dma_req_tag = 3'd1;
    chk("rst_txn_ready", 128'(bus.dma_req_ready), 128'(1));
    @(posedge clk); #1;
    bus.dma_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_txn_in_wait", 128'(bus.mem_req_valid), 128'(0));
    rst_l = 1'b0;
    #1;
    chk("async_rst_ready", 128'(bus.dma_req_ready), 128'(0));
    chk("async_rst_cnt", 128'(bus.dma_err_cnt), 128'(0));
    @(negedge clk);
    chk("rst_rsp_valid2", 128'(bus.dma_rsp_valid), 128'(0));
    rst_l = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
    chk("ready_after_rst2", 128'(bus.dma_req_ready), 128'(1));
    repeat (10) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 128'(bus.dma_rsp_valid), 128'(0));
    end
    chk("idle_ready_after_rst", 128'(bus.dma_req_ready), 128'(1));
    chk("err_cnt_after_rst", 128'(bus.dma_err_cnt), 128'(0));

    // Normal operation resumes
    mem_rsp_dly = 1; mem_data = 64'h0F0F_0F0F_F0F0_F0F0;
    send(32'hF004_0100, 3'd2, 1'b0, '0, 3'd5, 3'b001, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
